// File: rtl/status_arb.sv
// status_arb: round-robin arbiter and sequencer for the shared input-status
// mux path. Grants one requester, drives its select mask onto stat_sel, waits
// one settle cycle, captures the status word once, then holds the grant until
// the requester releases it.
//
// Optional feature: define STATUS_ARB_TIMEOUT_EN to enable a grant timeout of
// MAX_HOLD cycles (to_err pulse). Without it, to_err is tied low.
//
// Ports:
//   sysclk   in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   req      in   [NREQ]     request per requester, held high until done
//   mask     in   [NREQ*MW]  per-requester select mask, slice i = mask[i*MW +: MW]
//   stat_in  in   [SW]       status word from datapath mux
//   gnt      out  [NREQ]     one-hot grant
//   stat_sel out  [MW]       mux select (1 = first source, 0 = second source)
//   stat_out out  [SW]       captured status word
//   stat_vld out             1-cycle pulse, stat_out updated
//   busy     out             high whenever the FSM is not idle
//   to_err   out             1-cycle grant-timeout pulse
module status_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned SW       = 9,
  parameter int unsigned MW       = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*MW-1:0]   mask,
  input  logic [SW-1:0]        stat_in,
  output logic [NREQ-1:0]      gnt,
  output logic [MW-1:0]        stat_sel,
  output logic [SW-1:0]        stat_out,
  output logic                 stat_vld,
  output logic                 busy,
  output logic                 to_err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, CAPT, HOLD, REL} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   win;
  logic [MW-1:0]   win_mask;
  logic [NREQ-1:0] gnt_nxt;
  logic [MW-1:0]   sel_nxt;
  logic [SW-1:0]   out_nxt;
  logic            vld_nxt;
  logic            busy_nxt;

`ifdef STATUS_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_cnt, cnt_nxt;
  logic          to_err_nxt;
`endif

  // First set request searching upward from ptr+1, wrapping at NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] w;
    logic          found;
    logic [31:0]   idx;
    w     = p;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(p) + k) % NREQ;
      if (!found && r[PW'(idx)]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(req, ptr);

  // Mask slice of the prospective winner.
  always_comb begin
    win_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) win_mask = mask[i*MW +: MW];
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    sel_nxt   = stat_sel;
    out_nxt   = stat_out;
    vld_nxt   = 1'b0;
`ifdef STATUS_ARB_TIMEOUT_EN
    cnt_nxt    = hold_cnt;
    to_err_nxt = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = SETUP;
          ptr_nxt   = win;
          gnt_nxt   = NREQ'(1) << win;
          sel_nxt   = win_mask;
`ifdef STATUS_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      SETUP: begin
        state_nxt = CAPT;
`ifdef STATUS_ARB_TIMEOUT_EN
        cnt_nxt   = hold_cnt + HW'(1);
`endif
      end
      CAPT: begin
        out_nxt   = stat_in;
        vld_nxt   = 1'b1;
        state_nxt = HOLD;
`ifdef STATUS_ARB_TIMEOUT_EN
        cnt_nxt   = hold_cnt + HW'(1);
`endif
      end
      HOLD: begin
`ifdef STATUS_ARB_TIMEOUT_EN
        cnt_nxt = hold_cnt + HW'(1);
`endif
        if (!req[ptr]) begin
          gnt_nxt   = '0;
          sel_nxt   = '0;
          state_nxt = REL;
        end
`ifdef STATUS_ARB_TIMEOUT_EN
        else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
          gnt_nxt    = '0;
          sel_nxt    = '0;
          to_err_nxt = 1'b1;
          state_nxt  = REL;
        end
`endif
      end
      REL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; ptr resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      gnt      <= '0;
      stat_sel <= '0;
      stat_out <= '0;
      stat_vld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      stat_sel <= sel_nxt;
      stat_out <= out_nxt;
      stat_vld <= vld_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef STATUS_ARB_TIMEOUT_EN
  // Hold-time counter and timeout pulse.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      to_err   <= 1'b0;
    end else begin
      hold_cnt <= cnt_nxt;
      to_err   <= to_err_nxt;
    end
  end
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_status_arb.sv
module tb_status_arb;

  logic        sysclk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] mask;
  logic [8:0]  stat_in;
  logic [3:0]  gnt;
  logic [3:0]  stat_sel;
  logic [8:0]  stat_out;
  logic        stat_vld;
  logic        busy;
  logic        to_err;

  status_arb #(.NREQ(4), .SW(9), .MW(4), .MAX_HOLD(16)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .req      (req),
    .mask     (mask),
    .stat_in  (stat_in),
    .gnt      (gnt),
    .stat_sel (stat_sel),
    .stat_out (stat_out),
    .stat_vld (stat_vld),
    .busy     (busy),
    .to_err   (to_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] mask;
    logic [8:0]  stat_in;
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic [8:0]  out;
    logic        vld;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;

  // Shared scratch for the hand-written sequences
  logic [3:0] exp_g;
  logic [3:0] prev_g;
  int         n_g;
  int         last_c;
  int         drop;
  int         hit_at;

  localparam logic [15:0] M = 16'h73A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    mask    = M;
    stat_in = '0;

    // req, mask, stat_in | gnt, sel, out, vld, busy
    vecs.push_back('{4'b0000, M,        9'h1C5, 4'b0000, 4'h0, 9'h000, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, M,        9'h1C5, 4'b0010, 4'hA, 9'h000, 1'b0, 1'b1});
    vecs.push_back('{4'b0010, M,        9'h1C5, 4'b0010, 4'hA, 9'h000, 1'b0, 1'b1});
    vecs.push_back('{4'b0010, M,        9'h1C5, 4'b0010, 4'hA, 9'h1C5, 1'b1, 1'b1});
    vecs.push_back('{4'b0010, 16'hFFFF, 9'h0FF, 4'b0010, 4'hA, 9'h1C5, 1'b0, 1'b1});
    vecs.push_back('{4'b0010, 16'hFFFF, 9'h000, 4'b0010, 4'hA, 9'h1C5, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h000, 4'b0000, 4'h0, 9'h1C5, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h000, 4'b0000, 4'h0, 9'h1C5, 1'b0, 1'b0});
    vecs.push_back('{4'b0100, M,        9'h0AA, 4'b0100, 4'h3, 9'h1C5, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h0AA, 4'b0100, 4'h3, 9'h1C5, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h055, 4'b0100, 4'h3, 9'h055, 1'b1, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h055, 4'b0000, 4'h0, 9'h055, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h055, 4'b0000, 4'h0, 9'h055, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, M,        9'h055, 4'b0000, 4'h0, 9'h055, 1'b0, 1'b0});
    vecs.push_back('{4'b1001, M,        9'h100, 4'b1000, 4'h7, 9'h055, 1'b0, 1'b1});
    vecs.push_back('{4'b1001, M,        9'h100, 4'b1000, 4'h7, 9'h055, 1'b0, 1'b1});
    vecs.push_back('{4'b1001, M,        9'h100, 4'b1000, 4'h7, 9'h100, 1'b1, 1'b1});
    vecs.push_back('{4'b0001, M,        9'h100, 4'b0000, 4'h0, 9'h100, 1'b0, 1'b1});
    vecs.push_back('{4'b0001, M,        9'h100, 4'b0000, 4'h0, 9'h100, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, M,        9'h033, 4'b0001, 4'h5, 9'h100, 1'b0, 1'b1});
    vecs.push_back('{4'b0001, M,        9'h033, 4'b0001, 4'h5, 9'h100, 1'b0, 1'b1});
    vecs.push_back('{4'b0001, M,        9'h033, 4'b0001, 4'h5, 9'h033, 1'b1, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h033, 4'b0000, 4'h0, 9'h033, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, M,        9'h033, 4'b0000, 4'h0, 9'h033, 1'b0, 1'b0});

    // Reset values while reset is asserted
    tick();
    check("rst_gnt",  32'(gnt), 32'h0);
    check("rst_sel",  32'(stat_sel), 32'h0);
    check("rst_out",  32'(stat_out), 32'h0);
    check("rst_vld",  32'(stat_vld), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_toerr", 32'(to_err), 32'h0);
    reset = 1'b1;

    // Table-driven single-owner sequences
    foreach (vecs[i]) begin
      req     = vecs[i].req;
      mask    = vecs[i].mask;
      stat_in = vecs[i].stat_in;
      tick();
      check($sformatf("v%0d_gnt", i),  32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_sel", i),  32'(stat_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_out", i),  32'(stat_out), 32'(vecs[i].out));
      check($sformatf("v%0d_vld", i),  32'(stat_vld), 32'(vecs[i].vld));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_toerr", i), 32'(to_err), 32'h0);
    end

    // Reset asserted mid-HOLD clears outputs immediately
    req = 4'b0100;
    repeat (4) tick();
    check("pre_rst_gnt", 32'(gnt), 32'b0100);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_gnt",  32'(gnt), 32'h0);
    check("midrst_sel",  32'(stat_sel), 32'h0);
    check("midrst_out",  32'(stat_out), 32'h0);
    check("midrst_vld",  32'(stat_vld), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b1;
    req   = 4'b0001;
    tick();
    check("postrst_gnt", 32'(gnt), 32'b0001);
    check("postrst_sel", 32'(stat_sel), 32'h5);
    tick();
    check("postrst_novld", 32'(stat_vld), 32'h0);
    tick();
    check("postrst_vld", 32'(stat_vld), 32'h1);
    req = 4'b0000;
    repeat (2) tick();
    check("postrst_idle", 32'(busy), 32'h0);

    // Round-robin with all four requesters contending
    do_reset();
    req    = 4'hF;
    exp_g  = 4'b0001;
    prev_g = 4'b0000;
    n_g    = 0;
    last_c = 0;
    drop   = 0;
    for (int c = 1; c <= 100 && n_g < 5; c++) begin
      tick();
      if (gnt != 4'b0000 && prev_g == 4'b0000) begin
        check($sformatf("rr%0d_gnt", n_g), 32'(gnt), 32'(exp_g));
        if (n_g > 0) check($sformatf("rr%0d_spacing", n_g), 32'(c - last_c), 32'd7);
        last_c = c;
        n_g++;
        exp_g = {exp_g[2:0], exp_g[3]};
      end
      if (stat_vld) begin
        drop = 2;
      end else if (drop > 0) begin
        drop--;
        if (drop == 0) req = req & ~gnt;
      end
      if (gnt == 4'b0000) req = 4'hF;
      prev_g = gnt;
    end
    check("rr_grants", 32'(n_g), 32'd5);
    req = 4'b0000;
    repeat (8) tick();
    check("rr_idle", 32'(busy), 32'h0);

`ifdef STATUS_ARB_TIMEOUT_EN
    // Requester holding forever is timed out and re-granted later
    do_reset();
    req = 4'b0001;
    tick();
    check("to_gnt", 32'(gnt), 32'b0001);
    hit_at = 0;
    for (int i = 1; i <= 40 && hit_at == 0; i++) begin
      tick();
      if (to_err) hit_at = i;
    end
    check("to_delay", 32'(hit_at), 32'd16);
    check("to_gnt_off", 32'(gnt), 32'h0);
    tick();
    check("to_pulse", 32'(to_err), 32'h0);
    check("to_rel_gnt", 32'(gnt), 32'h0);
    tick();
    check("to_regrant", 32'(gnt), 32'b0001);
    req = 4'b0000;
    repeat (4) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
